// File: rtl/titan_mem_arbiter.sv
// Arbitrates one single-port memory bus between the fetch port (read-only) and the
// load/store port, sequencing one bus transaction at a time with a timeout and anti-starvation.
module titan_mem_arbiter #(
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] iport_addr_i,
  input  logic        iport_req_i,
  input  logic        iport_kill_i,
  output logic [31:0] iport_data_o,
  output logic        iport_rdy_o,
  output logic        iport_err_o,
  input  logic [31:0] dport_addr_i,
  input  logic [31:0] dport_wdata_i,
  input  logic [5:0]  dport_flags_i,
  input  logic        dport_req_i,
  output logic [31:0] dport_data_o,
  output logic        dport_rdy_o,
  output logic        dport_err_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_dat_o,
  output logic [3:0]  bus_sel_o,
  output logic        bus_we_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i,
  input  logic        bus_err_i
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_IBUS = 2'd1;
  localparam logic [1:0] S_DBUS = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] starve_q;
  logic [TW-1:0] tmo_q;
  logic [1:0]    lane_q;
  logic          word_q, hw_q, uns_q, killed_q, cyc_q, iport_rdy_q;
  logic          grant_i, grant_d, d_mis, d_bad, bus_end;
  logic [3:0]    d_sel;
  logic [31:0]   d_dat, ld_data;
  logic [15:0]   half_v;
  logic [7:0]    byte_v;
  logic          unused;

  assign unused = &{1'b0, iport_addr_i[1:0]};

  // A fetch killed while its response is being presented is not delivered.
  assign iport_rdy_o = iport_rdy_q & ~iport_kill_i;
  assign bus_cyc_o   = cyc_q;
  assign bus_stb_o   = cyc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Arbitration and next-state: dport has priority unless iport has been passed over too often.
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    d_mis   = dport_flags_i[3] ? (dport_addr_i[1:0] != 2'b00)
                               : (dport_flags_i[2] & dport_addr_i[0]);
    d_bad   = ~(dport_flags_i[5] | dport_flags_i[4]) | d_mis;
    bus_end = bus_ack_i | bus_err_i | (tmo_q == TMO_LAST);
    case (state_q)
      S_IDLE: begin
        grant_i = iport_req_i & ~iport_kill_i & (~dport_req_i | (starve_q == STARVE_LIM));
        grant_d = dport_req_i & ~grant_i;
        if (grant_i)      state_d = S_IBUS;
        else if (grant_d) state_d = d_bad ? S_RESP : S_DBUS;
      end
      S_IBUS, S_DBUS: if (bus_end) state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // Store lane placement from access size and address offset.
  always_comb begin
    d_sel = 4'b1111;
    d_dat = dport_wdata_i;
    if (!dport_flags_i[3]) begin
      if (dport_flags_i[2]) begin
        d_sel = dport_addr_i[1] ? 4'b1100 : 4'b0011;
        d_dat = {2{dport_wdata_i[15:0]}};
      end else begin
        d_sel = 4'b0001 << dport_addr_i[1:0];
        d_dat = {4{dport_wdata_i[7:0]}};
      end
    end
  end

  // Load alignment and extension from the lane captured at grant.
  always_comb begin
    half_v  = lane_q[1] ? bus_dat_i[31:16] : bus_dat_i[15:0];
    byte_v  = 8'(bus_dat_i >> {lane_q, 3'b000});
    ld_data = bus_dat_i;
    if (!word_q) begin
      if (hw_q) ld_data = uns_q ? {16'h0000, half_v} : {{16{half_v[15]}}, half_v};
      else      ld_data = uns_q ? {24'h000000, byte_v} : {{24{byte_v[7]}}, byte_v};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q     <= '0;
      tmo_q        <= '0;
      lane_q       <= '0;
      word_q       <= 1'b0;
      hw_q         <= 1'b0;
      uns_q        <= 1'b0;
      killed_q     <= 1'b0;
      cyc_q        <= 1'b0;
      iport_rdy_q  <= 1'b0;
      iport_err_o  <= 1'b0;
      iport_data_o <= '0;
      dport_rdy_o  <= 1'b0;
      dport_err_o  <= 1'b0;
      dport_data_o <= '0;
      bus_addr_o   <= '0;
      bus_dat_o    <= '0;
      bus_sel_o    <= '0;
      bus_we_o     <= 1'b0;
    end else begin
      iport_rdy_q <= 1'b0;
      dport_rdy_o <= 1'b0;

      if (!iport_req_i || grant_i)                   starve_q <= '0;
      else if (grant_d && (starve_q != STARVE_LIM)) starve_q <= starve_q + SW'(1);

      case (state_q)
        S_IDLE: begin
          tmo_q <= '0;
          if (grant_i) begin
            bus_addr_o <= {iport_addr_i[31:2], 2'b00};
            bus_sel_o  <= 4'b1111;
            bus_we_o   <= 1'b0;
            cyc_q      <= 1'b1;
            killed_q   <= 1'b0;
          end else if (grant_d) begin
            if (d_bad) begin
              dport_rdy_o <= 1'b1;
              dport_err_o <= 1'b1;
            end else begin
              bus_addr_o <= {dport_addr_i[31:2], 2'b00};
              bus_dat_o  <= d_dat;
              bus_sel_o  <= d_sel;
              bus_we_o   <= dport_flags_i[5];
              cyc_q      <= 1'b1;
              lane_q     <= dport_addr_i[1:0];
              word_q     <= dport_flags_i[3];
              hw_q       <= dport_flags_i[2];
              uns_q      <= dport_flags_i[0];
            end
          end
        end
        S_IBUS, S_DBUS: begin
          if (state_q == S_IBUS && iport_kill_i) killed_q <= 1'b1;
          if (bus_end) begin
            cyc_q <= 1'b0;
            tmo_q <= '0;
            // Error wins over ack; neither means the timeout fired.
            if (state_q == S_IBUS) begin
              iport_rdy_q  <= ~(killed_q | iport_kill_i);
              iport_err_o  <= bus_err_i | ~bus_ack_i;
              iport_data_o <= bus_dat_i;
            end else begin
              dport_rdy_o  <= 1'b1;
              dport_err_o  <= bus_err_i | ~bus_ack_i;
              dport_data_o <= ld_data;
            end
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_titan_mem_arbiter.sv
// Bench for titan_mem_arbiter: byte-level memory reference model, scoreboard queues per port,
// reactive bus slave, directed corner cases and randomized concurrent traffic.
module tb_titan_mem_arbiter;

  localparam int unsigned TIMEOUT    = 16;
  localparam int unsigned STARVE_MAX = 2;
  localparam logic [5:0] LW  = 6'b011000;
  localparam logic [5:0] LB  = 6'b010010;
  localparam logic [5:0] LBU = 6'b010011;
  localparam logic [5:0] LHU = 6'b010101;
  localparam logic [5:0] SH  = 6'b100100;
  localparam logic [5:0] SW  = 6'b101000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] iport_addr_i = '0;
  logic        iport_req_i = 1'b0, iport_kill_i = 1'b0;
  logic [31:0] iport_data_o;
  logic        iport_rdy_o, iport_err_o;
  logic [31:0] dport_addr_i = '0, dport_wdata_i = '0;
  logic [5:0]  dport_flags_i = '0;
  logic        dport_req_i = 1'b0;
  logic [31:0] dport_data_o;
  logic        dport_rdy_o, dport_err_o;
  logic [31:0] bus_addr_o, bus_dat_o;
  logic [3:0]  bus_sel_o;
  logic        bus_we_o, bus_cyc_o, bus_stb_o;
  logic [31:0] bus_dat_i = '0;
  logic        bus_ack_i = 1'b0, bus_err_i = 1'b0;

  always #5 clk = ~clk;

  titan_mem_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .iport_addr_i(iport_addr_i), .iport_req_i(iport_req_i), .iport_kill_i(iport_kill_i),
    .iport_data_o(iport_data_o), .iport_rdy_o(iport_rdy_o), .iport_err_o(iport_err_o),
    .dport_addr_i(dport_addr_i), .dport_wdata_i(dport_wdata_i), .dport_flags_i(dport_flags_i),
    .dport_req_i(dport_req_i), .dport_data_o(dport_data_o), .dport_rdy_o(dport_rdy_o),
    .dport_err_o(dport_err_o), .bus_addr_o(bus_addr_o), .bus_dat_o(bus_dat_o),
    .bus_sel_o(bus_sel_o), .bus_we_o(bus_we_o), .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o),
    .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        chk_data;
  } exp_t;

  int checks = 0;
  int errors = 0;
  exp_t iq[$];
  exp_t dq[$];
  logic [31:0] rmem[int unsigned];
  logic [31:0] smem[int unsigned];
  int slave_mode = 0;
  int cyc_cycles = 0;
  int irdy_seen = 0;
  logic [31:0] snap_addr, snap_dat;
  logic [3:0]  snap_sel;
  logic        snap_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Initial memory content, a fixed function of the word address.
  function automatic logic [31:0] dflt(input int unsigned wa);
    return (wa * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  function automatic int unsigned region(input logic [31:0] a);
    return 32'((a >> 12) & 32'hF);
  endfunction

  function automatic logic [31:0] ref_word(input int unsigned wa);
    if (rmem.exists(wa)) return rmem[wa];
    return dflt(wa);
  endfunction

  function automatic logic [7:0] ref_byte(input int unsigned a);
    logic [31:0] w;
    w = ref_word(a >> 2);
    return w[8*(a%4) +: 8];
  endfunction

  task automatic ref_set_byte(input int unsigned a, input logic [7:0] b);
    logic [31:0] w;
    w = ref_word(a >> 2);
    w[8*(a%4) +: 8] = b;
    rmem[a >> 2] = w;
  endtask

  function automatic logic [31:0] slave_word(input int unsigned wa);
    if (smem.exists(wa)) return smem[wa];
    return dflt(wa);
  endfunction

  task automatic issue_i(input logic [31:0] a);
    exp_t e;
    e.err      = region(a) inside {14, 15};
    e.data     = ref_word(a >> 2);
    e.chk_data = !e.err;
    iq.push_back(e);
    iport_addr_i = a;
    iport_req_i  = 1'b1;
  endtask

  // Reference: an access of n bytes at address a, little-endian, sign-extended unless unsigned.
  task automatic issue_d(input logic [31:0] a, input logic [31:0] wd, input logic [5:0] f);
    exp_t e;
    int unsigned n;
    logic [31:0] v;
    n = f[3] ? 4 : (f[2] ? 2 : 1);
    e.err = !(f[5] | f[4]) || ((a % n) != 0) || (region(a) inside {14, 15});
    e.chk_data = 1'b0;
    e.data = '0;
    if (!e.err && f[5]) begin
      for (int i = 0; i < int'(n); i++) ref_set_byte(a + 32'(i), wd[8*i +: 8]);
    end else if (!e.err) begin
      v = '0;
      for (int i = 0; i < int'(n); i++) v = v | (32'(ref_byte(a + 32'(i))) << (8*i));
      if (!f[0] && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
      e.data = v;
      e.chk_data = 1'b1;
    end
    dq.push_back(e);
    dport_addr_i  = a;
    dport_wdata_i = wd;
    dport_flags_i = f;
    dport_req_i   = 1'b1;
  endtask

  task automatic wait_rdy(input bit is_d, input int limit, output int n);
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < limit) begin
      @(negedge clk);
      n++;
      seen = is_d ? dport_rdy_o : iport_rdy_o;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_rdy_wait act=no_pulse exp=pulse_within_%0d_cycles", is_d ? "dport" : "iport", limit);
    end
  endtask

  // Scoreboard monitor: pops the oldest expectation whenever a port completes.
  always @(negedge clk) begin
    exp_t e;
    if (iport_rdy_o) begin
      irdy_seen++;
      if (iq.size() == 0) begin
        checks++; errors++;
        $display("FAIL iport_unexpected_rdy act=1 exp=0 at %0t", $time);
      end else begin
        e = iq.pop_front();
        chk("iport_err", 32'(iport_err_o), 32'(e.err));
        if (e.chk_data) chk("iport_data", iport_data_o, e.data);
      end
    end
    if (dport_rdy_o) begin
      if (dq.size() == 0) begin
        checks++; errors++;
        $display("FAIL dport_unexpected_rdy act=1 exp=0 at %0t", $time);
      end else begin
        e = dq.pop_front();
        chk("dport_err", 32'(dport_err_o), 32'(e.err));
        if (e.chk_data) chk("dport_data", dport_data_o, e.data);
      end
    end
  end

  // Bus slave: mode 0 random latency with E/F regions erroring/silent, 1 immediate ack,
  // 2 never responds, 3 ack+err together, 4 ack after two wait cycles.
  bit busy = 1'b0;
  int dly = 0;
  int resp = 0;
  always @(negedge clk) begin
    bus_ack_i = 1'b0;
    bus_err_i = 1'b0;
    bus_dat_i = $urandom;
    if (!bus_cyc_o) begin
      busy = 1'b0;
    end else begin
      cyc_cycles++;
      if (!busy) begin
        busy = 1'b1;
        snap_addr = bus_addr_o; snap_dat = bus_dat_o; snap_sel = bus_sel_o; snap_we = bus_we_o;
        chk("bus_stb_eq_cyc", 32'(bus_stb_o), 32'(1));
        chk("bus_addr_align", 32'(bus_addr_o[1:0]), 32'(0));
        case (slave_mode)
          0: begin
            dly  = int'($urandom_range(0, 3));
            resp = (region(bus_addr_o) == 15) ? 0 : ((region(bus_addr_o) == 14) ? 2 : 1);
          end
          1: begin dly = 0; resp = 1; end
          3: begin dly = 0; resp = 3; end
          4: begin dly = 2; resp = 1; end
          default: begin dly = 0; resp = 0; end
        endcase
      end
      if (resp != 0) begin
        if (dly == 0) begin
          if (resp == 1) begin
            bus_ack_i = 1'b1;
            if (bus_we_o) begin
              logic [31:0] w;
              w = slave_word(bus_addr_o >> 2);
              for (int l = 0; l < 4; l++) if (bus_sel_o[l]) w[8*l +: 8] = bus_dat_o[8*l +: 8];
              smem[bus_addr_o >> 2] = w;
            end else begin
              bus_dat_i = slave_word(bus_addr_o >> 2);
            end
          end else begin
            bus_err_i = 1'b1;
            bus_ack_i = (resp == 3) ? 1'b1 : 1'($urandom_range(0, 1));
          end
          resp = 0;
        end else begin
          dly--;
        end
      end
    end
  end

  function automatic logic [31:0] rand_iaddr();
    logic [31:0] a;
    int unsigned r;
    a = 32'($urandom_range(0, 1023)) << 2;
    r = $urandom_range(0, 15);
    if (r == 0) a[15:12] = 4'hE;
    if (r == 1) a[15:12] = 4'hF;
    return a;
  endfunction

  initial begin
    int n;
    int base;
    bit ord[$];
    logic [31:0] ia, da;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_iport_rdy", 32'(iport_rdy_o), 32'(0));
    chk("rst_dport_rdy", 32'(dport_rdy_o), 32'(0));
    chk("rst_bus_cyc", 32'(bus_cyc_o), 32'(0));
    chk("rst_bus_addr", bus_addr_o, 32'(0));
    chk("rst_bus_sel", 32'(bus_sel_o), 32'(0));
    chk("rst_dport_data", dport_data_o, 32'(0));
    rst_i = 1'b0;
    @(negedge clk);

    // Minimum-latency fetch
    slave_mode = 1;
    issue_i(32'h100);
    wait_rdy(0, 20, n);
    chk("fetch_latency", 32'(n), 32'(2));
    chk("fetch_sel", 32'(snap_sel), 32'hF);
    chk("fetch_we", 32'(snap_we), 32'(0));
    chk("fetch_addr", snap_addr, 32'h100);
    iport_req_i = 1'b0;

    // Signed/unsigned byte loads from the top lane
    rmem[32'h200 >> 2] = 32'h80A1B2C3;
    smem[32'h200 >> 2] = 32'h80A1B2C3;
    issue_d(32'h203, 32'h0, LB);
    wait_rdy(1, 20, n);
    chk("lb_sext", dport_data_o, 32'hFFFFFF80);
    dport_req_i = 1'b0;
    @(negedge clk);
    issue_d(32'h203, 32'h0, LBU);
    wait_rdy(1, 20, n);
    chk("lbu_zext", dport_data_o, 32'h00000080);
    dport_req_i = 1'b0;

    // Halfword store lanes, read-back, and misaligned halfword
    @(negedge clk);
    issue_d(32'h202, 32'h1234BEEF, SH);
    wait_rdy(1, 20, n);
    chk("sh_sel", 32'(snap_sel), 32'hC);
    chk("sh_dat", snap_dat, 32'hBEEFBEEF);
    chk("sh_we", 32'(snap_we), 32'(1));
    dport_req_i = 1'b0;
    @(negedge clk);
    issue_d(32'h202, 32'h0, LHU);
    wait_rdy(1, 20, n);
    chk("lhu_readback", dport_data_o, 32'h0000BEEF);
    dport_req_i = 1'b0;
    @(negedge clk);
    cyc_cycles = 0;
    issue_d(32'h201, 32'hBEEF, SH);
    wait_rdy(1, 20, n);
    chk("sh_mis_err", 32'(dport_err_o), 32'(1));
    chk("sh_mis_no_cyc", 32'(cyc_cycles), 32'(0));
    dport_req_i = 1'b0;

    // Timeout on a silent bus
    @(negedge clk);
    slave_mode = 2;
    cyc_cycles = 0;
    issue_i(32'hF100);
    wait_rdy(0, 60, n);
    chk("timeout_err", 32'(iport_err_o), 32'(1));
    chk("timeout_cycles", 32'(cyc_cycles), 32'(TIMEOUT));
    chk("timeout_cyc_drop", 32'(bus_cyc_o), 32'(0));
    iport_req_i = 1'b0;

    // Error together with ack
    @(negedge clk);
    slave_mode = 3;
    issue_d(32'hE004, 32'h0, LW);
    wait_rdy(1, 20, n);
    chk("err_with_ack", 32'(dport_err_o), 32'(1));
    dport_req_i = 1'b0;

    // Kill during the bus phase of a fetch
    @(negedge clk);
    slave_mode = 4;
    iport_addr_i = 32'h140;
    iport_req_i = 1'b1;
    n = 0;
    while (!bus_cyc_o && n < 20) begin @(negedge clk); n++; end
    chk("kill_cyc_started", 32'(bus_cyc_o), 32'(1));
    base = irdy_seen;
    iport_kill_i = 1'b1;
    iport_req_i = 1'b0;
    @(negedge clk);
    iport_kill_i = 1'b0;
    repeat (10) @(negedge clk);
    chk("kill_no_rdy", 32'(irdy_seen - base), 32'(0));
    chk("kill_bus_done", 32'(bus_cyc_o), 32'(0));

    // Reset in the middle of a data transaction
    slave_mode = 2;
    dport_addr_i = 32'h1100; dport_wdata_i = 32'h12345678; dport_flags_i = SW; dport_req_i = 1'b1;
    n = 0;
    while (!bus_cyc_o && n < 20) begin @(negedge clk); n++; end
    chk("rstmid_cyc_started", 32'(bus_cyc_o), 32'(1));
    #2 rst_i = 1'b1;
    #1;
    chk("rstmid_cyc", 32'(bus_cyc_o), 32'(0));
    chk("rstmid_stb", 32'(bus_stb_o), 32'(0));
    chk("rstmid_dport_rdy", 32'(dport_rdy_o), 32'(0));
    dport_req_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    slave_mode = 1;
    issue_i(32'h104);
    wait_rdy(0, 20, n);
    chk("rstmid_idle_latency", 32'(n), 32'(2));
    iport_req_i = 1'b0;
    @(negedge clk);

    // Grant order with both ports continuously requesting
    ia = 32'h300;
    da = 32'h1010;
    issue_i(ia);
    issue_d(da, 32'h0, LW);
    n = 0;
    while (ord.size() < 6 && n < 300) begin
      @(negedge clk);
      n++;
      if (dport_rdy_o) begin ord.push_back(1'b1); da = da + 4; issue_d(da, 32'h0, LW); end
      if (iport_rdy_o) begin ord.push_back(1'b0); ia = ia + 4; issue_i(ia); end
    end
    for (int k = 0; k < 6; k++) begin
      if (k < ord.size()) chk($sformatf("grant_order_%0d", k), 32'(ord[k]), 32'(k % 3 != 2));
      else begin checks++; errors++; $display("FAIL grant_order_%0d act=missing exp=grant", k); end
    end
    n = 0;
    while ((iport_req_i || dport_req_i) && n < 300) begin
      @(negedge clk);
      n++;
      if (dport_rdy_o) dport_req_i = 1'b0;
      if (iport_rdy_o) iport_req_i = 1'b0;
    end
    chk("grant_drain", 32'(iport_req_i | dport_req_i), 32'(0));

    // Randomized concurrent traffic on both ports
    slave_mode = 0;
    fork
      begin : ifetch_drv
        int m;
        for (int k = 0; k < 120; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          issue_i(rand_iaddr());
          wait_rdy(0, 200, m);
          iport_req_i = 1'b0;
        end
      end
      begin : data_drv
        int m;
        logic [31:0] a;
        logic [5:0] f;
        int unsigned sz, op, r, off;
        for (int k = 0; k < 120; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          sz = $urandom_range(0, 2);
          op = $urandom_range(0, 9);
          f = '0;
          f[3 - sz] = 1'b1;
          f[0] = 1'($urandom_range(0, 1));
          if (op >= 5) f[5] = 1'b1;
          else if (op >= 1) f[4] = 1'b1;
          off = $urandom_range(0, 3);
          if ($urandom_range(0, 3) != 0) off = (sz == 0) ? 0 : ((sz == 1) ? (off & 2) : off);
          a = 32'h1000 + (32'($urandom_range(0, 63)) << 2) + 32'(off);
          r = $urandom_range(0, 15);
          if (r == 0) a[15:12] = 4'hE;
          if (r == 1) a[15:12] = 4'hF;
          issue_d(a, $urandom, f);
          wait_rdy(1, 200, m);
          dport_req_i = 1'b0;
        end
      end
    join
    repeat (5) @(negedge clk);
    chk("iq_drained", 32'(iq.size()), 32'(0));
    chk("dq_drained", 32'(dq.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
